// File: rtl/request_dispatcher.sv
// Pending-floor request dispatcher: ordered request list feeding one registered target floor.
// Define DISPATCH_NEAREST_EN to pick the entry nearest piso_actual instead of the oldest one.
module request_dispatcher #(
    parameter int DEPTH = 11,
    parameter int W     = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         agregar,
    input  logic [W-1:0] boton,
    input  logic [W-1:0] piso_actual,
    input  logic         llegada,
    output logic [W-1:0] destino,
    output logic         destino_valido,
    output logic [W-1:0] ocupacion,
    output logic         lleno,
    output logic         desbordado
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SELECT = 2'd1,
        ST_WAIT   = 2'd2,
        ST_REMOVE = 2'd3
    } state_t;

    localparam logic [W-1:0] DEPTH_W = W'(DEPTH);
    localparam logic [W-1:0] ONE_W   = W'(1);

    state_t       state_r;
    state_t       state_nxt_s;
    logic [W-1:0] entry_r     [DEPTH];
    logic [W-1:0] entry_nxt_s [DEPTH];
    logic [W-1:0] ocup_r;
    logic [W-1:0] ocup_nxt_s;
    logic [W-1:0] ocup_m1_s;
    logic [W-1:0] sel_r;
    logic [W-1:0] pick_idx_s;
    logic [W-1:0] pick_val_s;
    logic [W-1:0] destino_r;
    logic         valid_r;
    logic         lleno_r;
    logic         desb_r;
    logic         desb_nxt_s;

    assign ocup_m1_s = ocup_r - ONE_W;

`ifdef DISPATCH_NEAREST_EN
    logic [W-1:0] best_s;

    function automatic logic [W-1:0] abs_diff(input logic [W-1:0] a, input logic [W-1:0] b);
        if (a >= b) begin
            return a - b;
        end else begin
            return b - a;
        end
    endfunction

    // Nearest valid entry to the car; strict compare keeps ties on the lowest index.
    always_comb begin
        pick_idx_s = '0;
        best_s     = abs_diff(entry_r[0], piso_actual);
        for (int i = 1; i < DEPTH; i++) begin
            if ((W'(i) < ocup_r) && (abs_diff(entry_r[i], piso_actual) < best_s)) begin
                pick_idx_s = W'(i);
                best_s     = abs_diff(entry_r[i], piso_actual);
            end else begin
                pick_idx_s = pick_idx_s;
                best_s     = best_s;
            end
        end
    end
`else
    logic unused_piso_s;

    assign unused_piso_s = ^piso_actual;

    // Oldest entry is always served first.
    always_comb begin
        pick_idx_s = '0;
    end
`endif

    // Value of the entry currently picked for service.
    always_comb begin
        pick_val_s = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (W'(i) == pick_idx_s) begin
                pick_val_s = entry_r[i];
            end else begin
                pick_val_s = pick_val_s;
            end
        end
    end

    // Dispatch sequencing: pick, wait for arrival, retire.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (ocup_r != '0) begin
                    state_nxt_s = ST_SELECT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SELECT: begin
                state_nxt_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (llegada) begin
                    state_nxt_s = ST_REMOVE;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_REMOVE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // List update: removal with shift-down, tail append, overflow detection.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entry_nxt_s[i] = entry_r[i];
        end
        ocup_nxt_s = ocup_r;
        desb_nxt_s = 1'b0;
        if ((state_r == ST_REMOVE) && (ocup_r != '0)) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                if (W'(i) >= sel_r) begin
                    entry_nxt_s[i] = entry_r[i + 1];
                end else begin
                    entry_nxt_s[i] = entry_r[i];
                end
            end
            entry_nxt_s[DEPTH-1] = '0;
            // The slot freed by the shift is reused by a same-cycle push, so a full list still accepts it.
            if (agregar) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (W'(i) == ocup_m1_s) begin
                        entry_nxt_s[i] = boton;
                    end else begin
                        entry_nxt_s[i] = entry_nxt_s[i];
                    end
                end
                ocup_nxt_s = ocup_r;
            end else begin
                ocup_nxt_s = ocup_m1_s;
            end
        end else if (agregar) begin
            if (ocup_r < DEPTH_W) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (W'(i) == ocup_r) begin
                        entry_nxt_s[i] = boton;
                    end else begin
                        entry_nxt_s[i] = entry_r[i];
                    end
                end
                ocup_nxt_s = ocup_r + ONE_W;
            end else begin
                desb_nxt_s = 1'b1;
            end
        end else begin
            ocup_nxt_s = ocup_r;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Entry storage and occupancy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_r[i] <= '0;
            end
            ocup_r <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_r[i] <= entry_nxt_s[i];
            end
            ocup_r <= ocup_nxt_s;
        end
    end

    // Chosen index and target are frozen at selection so later pushes cannot disturb them.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sel_r     <= '0;
            destino_r <= '0;
        end else if (state_r == ST_SELECT) begin
            sel_r     <= pick_idx_s;
            destino_r <= pick_val_s;
        end else begin
            sel_r     <= sel_r;
            destino_r <= destino_r;
        end
    end

    // Registered status flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_r <= 1'b0;
            lleno_r <= 1'b0;
            desb_r  <= 1'b0;
        end else begin
            valid_r <= (state_nxt_s == ST_WAIT);
            lleno_r <= (ocup_nxt_s == DEPTH_W);
            desb_r  <= desb_nxt_s;
        end
    end

    assign destino        = destino_r;
    assign destino_valido = valid_r;
    assign ocupacion      = ocup_r;
    assign lleno          = lleno_r;
    assign desbordado     = desb_r;

endmodule

// File: tb/tb_request_dispatcher.sv
// Self-checking bench for request_dispatcher: list/queue reference model plus directed literal checks.
module tb_request_dispatcher;
    localparam int DEPTH = 11;
    localparam int W     = 4;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         agregar = 1'b0;
    logic [W-1:0] boton = '0;
    logic [W-1:0] piso_actual = '0;
    logic         llegada = 1'b0;
    logic [W-1:0] destino;
    logic         destino_valido;
    logic [W-1:0] ocupacion;
    logic         lleno;
    logic         desbordado;

    request_dispatcher #(.DEPTH(DEPTH), .W(W)) dut (
        .clk(clk), .reset_n(reset_n), .agregar(agregar), .boton(boton),
        .piso_actual(piso_actual), .llegada(llegada), .destino(destino),
        .destino_valido(destino_valido), .ocupacion(ocupacion), .lleno(lleno),
        .desbordado(desbordado)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    // Reference model: pending list, service phase (0 idle,1 select,2 wait,3 remove), chosen slot.
    int q[$];
    int ph = 0;
    int sel = 0;
    int exp_dest = 0;
    int exp_desb = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic int absd(input int a, input int b);
        return (a > b) ? a - b : b - a;
    endfunction

    function automatic int choose();
        int b = 0;
`ifdef DISPATCH_NEAREST_EN
        for (int i = 1; i < q.size(); i++)
            if (absd(q[i], int'(piso_actual)) < absd(q[b], int'(piso_actual))) b = i;
`endif
        return b;
    endfunction

    // Advance the model over one edge using the inputs now applied, then compare after the edge.
    task automatic cyc();
        int n_before = q.size();
        int old_ph = ph;
        exp_desb = 0;
        case (old_ph)
            0: if (n_before > 0) ph = 1;
            1: begin sel = choose(); exp_dest = q[sel]; ph = 2; end
            2: if (llegada) ph = 3;
            default: ph = 0;
        endcase
        if (old_ph == 3) begin
            q.delete(sel);
            if (agregar) q.push_back(int'(boton));
        end else if (agregar) begin
            if (q.size() < DEPTH) q.push_back(int'(boton));
            else exp_desb = 1;
        end
        @(posedge clk);
        #1;
        chk("valid", int'(destino_valido), (ph == 2) ? 1 : 0);
        chk("ocupacion", int'(ocupacion), q.size());
        chk("lleno", int'(lleno), (q.size() == DEPTH) ? 1 : 0);
        chk("desbordado", int'(desbordado), exp_desb);
        if (ph == 2) chk("destino", int'(destino), exp_dest);
    endtask

    task automatic wait_valid(input int max);
        for (int k = 0; k < max && !destino_valido; k++) cyc();
        chk("wait_valid_timeout", int'(destino_valido), 1);
    endtask

    task automatic serve(output int d);
        wait_valid(8);
        d = int'(destino);
        llegada = 1'b1;
        cyc();
        llegada = 1'b0;
        cyc();
    endtask

    task automatic do_reset();
        #2 reset_n = 1'b0;
        #1;
        chk("rst_destino", int'(destino), 0);
        chk("rst_valid", int'(destino_valido), 0);
        chk("rst_ocupacion", int'(ocupacion), 0);
        chk("rst_lleno", int'(lleno), 0);
        chk("rst_desbordado", int'(desbordado), 0);
        q.delete();
        ph = 0;
        sel = 0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        int d;
        #12;
        chk("init_destino", int'(destino), 0);
        chk("init_valid", int'(destino_valido), 0);
        chk("init_ocupacion", int'(ocupacion), 0);
        chk("init_lleno", int'(lleno), 0);
        chk("init_desbordado", int'(desbordado), 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Push 5 then 2: valid with 5 two edges after the first push, then 2 with one left.
        piso_actual = 4'd5;
        agregar = 1'b1; boton = 4'd5; cyc();
        boton = 4'd2; cyc();
        agregar = 1'b0; cyc();
        chk("p032_valid", int'(destino_valido), 1);
        chk("p032_destino5", int'(destino), 5);
        llegada = 1'b1; cyc();
        llegada = 1'b0; cyc(); cyc(); cyc();
        chk("p032_destino2", int'(destino), 2);
        chk("p032_ocup1", int'(ocupacion), 1);
        serve(d);
        cyc();
        chk("p032_empty", int'(ocupacion), 0);

        // Fill with 11 distinct codes, then a dropped push while waiting.
        piso_actual = 4'd0;
        agregar = 1'b1;
        for (int i = 1; i <= DEPTH; i++) begin boton = 4'(i); cyc(); end
        boton = 4'd7; cyc();
        agregar = 1'b0;
        chk("p033_desb", int'(desbordado), 1);
        chk("p033_lleno", int'(lleno), 1);
        chk("p033_ocup", int'(ocupacion), 11);
        cyc();
        chk("p033_desb_once", int'(desbordado), 0);

        // Arrival then push 9 on the removal edge of a full list.
        llegada = 1'b1; cyc();
        llegada = 1'b0; agregar = 1'b1; boton = 4'd9; cyc();
        agregar = 1'b0;
        chk("p034_ocup", int'(ocupacion), 11);
        chk("p034_lleno", int'(lleno), 1);
        for (int i = 0; i < DEPTH; i++) serve(d);
`ifdef DISPATCH_NEAREST_EN
        chk("p034_last", d, 11);
`else
        chk("p034_last_is_9", d, 9);
`endif
        cyc();
        chk("p034_empty", int'(ocupacion), 0);

        // Reset during the wait for floor 3 abandons it.
        piso_actual = 4'd3;
        agregar = 1'b1; boton = 4'd3; cyc();
        agregar = 1'b0;
        wait_valid(6);
        chk("p035_destino3", int'(destino), 3);
        do_reset();
        for (int i = 0; i < 6; i++) cyc();
        chk("p035_no_destino", int'(destino_valido), 0);
        chk("p035_ocup", int'(ocupacion), 0);

        // Arrival strobe with nothing pending is ignored.
        llegada = 1'b1; cyc(); cyc();
        llegada = 1'b0; cyc();
        chk("p037_ocup", int'(ocupacion), 0);
        chk("p037_valid", int'(destino_valido), 0);

`ifdef DISPATCH_NEAREST_EN
        // Nearest order from floor 4 over {9,2,6,5}, behind a leading request for floor 4.
        piso_actual = 4'd4;
        agregar = 1'b1; boton = 4'd4; cyc();
        agregar = 1'b0;
        wait_valid(6);
        agregar = 1'b1;
        boton = 4'd9; cyc(); boton = 4'd2; cyc(); boton = 4'd6; cyc(); boton = 4'd5; cyc();
        agregar = 1'b0;
        serve(d);
        serve(d); chk("p036_first", d, 5); piso_actual = 4'd5;
        serve(d); chk("p036_second", d, 6); piso_actual = 4'd6;
        serve(d); chk("p036_third", d, 9); piso_actual = 4'd9;
        serve(d); chk("p036_fourth", d, 2);
`endif

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            agregar     = ($urandom_range(0, 99) < 45);
            boton       = 4'($urandom_range(0, 15));
            llegada     = ($urandom_range(0, 99) < 30);
            piso_actual = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 499) == 0) do_reset();
            cyc();
        end
        agregar = 1'b0;
        llegada = 1'b0;

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
